seq_mult_sgn: RTL and testbench

- Parametrised sequential shift-add multiplier with per-transaction signed/unsigned mode.
- Replaces the fixed 8-bit combinational adder-tree multiplier where area matters more than latency.
- Valid/ready handshake on both operand and result sides; one multiplication in flight.
- Sits in the arithmetic library between operand staging registers and the accumulator/ALU result path.

---
 rtl/mult_pkg.sv | 24 ++
 rtl/cond_negate.sv | 12 +
 rtl/seq_mult_sgn.sv | 181 ++++++++++++++++++
 tb/tb_seq_mult_sgn.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAG_MAX_W = 64;

    // Conditional two's-complement magnitude of an operand held in the low bits of x.
    function automatic logic [MAG_MAX_W-1:0] cond_mag(input logic [MAG_MAX_W-1:0] x,
                                                      input logic neg);
        logic [MAG_MAX_W-1:0] r;
        if (neg) begin
            r = ~x + {{(MAG_MAX_W-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/cond_negate.sv
// Width-parametrised conditional two's-complement negation: y = neg ? -x : x.
module cond_negate #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_mult_sgn.sv
// Sequential shift-add multiplier, N x N -> 2N, per-transaction signed/unsigned mode.
// Optional build macro MULT_EARLY_EXIT_EN stops iterating once the multiplier runs out of set bits.
module seq_mult_sgn
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int CNT_W = $clog2(N);
    localparam int W2    = 2 * N;

    state_t           state_r;
    state_t           state_next_s;
    logic [W2-1:0]    ma_sh_r;
    logic [N-1:0]     mb_r;
    logic [W2-1:0]    acc_r;
    logic             neg_r;
    logic [CNT_W-1:0] count_r;
    logic [W2-1:0]    product_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [N-1:0]     a_mag_s;
    logic [N-1:0]     b_mag_s;
    logic [W2-1:0]    acc_next_s;
    logic [N-1:0]     mb_shift_s;
    logic [W2-1:0]    prod_fix_s;
    logic             last_s;
    logic             in_ready_nxt_s;
    logic             out_valid_nxt_s;

    cond_negate #(.W(N)) u_mag_a (
        .x   (a),
        .neg (is_signed & a[N-1]),
        .y   (a_mag_s)
    );

    cond_negate #(.W(N)) u_mag_b (
        .x   (b),
        .neg (is_signed & b[N-1]),
        .y   (b_mag_s)
    );

    cond_negate #(.W(W2)) u_fix (
        .x   (acc_next_s),
        .neg (neg_r),
        .y   (prod_fix_s)
    );

    assign acc_next_s = acc_r + (mb_r[0] ? ma_sh_r : {W2{1'b0}});
    assign mb_shift_s = mb_r >> 1;

`ifdef MULT_EARLY_EXIT_EN
    assign last_s = (count_r == CNT_W'(N - 1)) || (mb_shift_s == {N{1'b0}});
`else
    assign last_s = (count_r == CNT_W'(N - 1));
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Handshake outputs derived from the upcoming state so they can be registered
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        case (state_next_s)
            IDLE: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
            end
            DONE: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Shift-add datapath; product only changes on the BUSY -> DONE step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_sh_r   <= {W2{1'b0}};
            mb_r      <= {N{1'b0}};
            acc_r     <= {W2{1'b0}};
            neg_r     <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            product_r <= {W2{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        ma_sh_r <= {{N{1'b0}}, a_mag_s};
                        mb_r    <= b_mag_s;
                        neg_r   <= is_signed & (a[N-1] ^ b[N-1]);
                        acc_r   <= {W2{1'b0}};
                        count_r <= {CNT_W{1'b0}};
                    end
                end
                BUSY: begin
                    acc_r   <= acc_next_s;
                    ma_sh_r <= ma_sh_r << 1;
                    mb_r    <= mb_shift_s;
                    count_r <= count_r + CNT_W'(1);
                    if (last_s) begin
                        product_r <= prod_fix_s;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign product   = product_r;

endmodule

// File: tb/tb_seq_mult_sgn.sv
// Scoreboard bench for seq_mult_sgn (N=8); latency expectations follow MULT_EARLY_EXIT_EN.
module tb_seq_mult_sgn;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    vec_t tbl [13] = '{
        '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
        '{8'h80, 8'h80, 1'b1, 16'h4000},
        '{8'hFD, 8'h05, 1'b1, 16'hFFF1},
        '{8'hFD, 8'h05, 1'b0, 16'h04F1},
        '{8'h7F, 8'h80, 1'b1, 16'hC080},
        '{8'h80, 8'h7F, 1'b1, 16'hC080},
        '{8'h00, 8'hA5, 1'b1, 16'h0000},
        '{8'hFF, 8'h01, 1'b1, 16'hFFFF},
        '{8'h80, 8'h01, 1'b0, 16'h0080},
        '{8'h01, 8'h80, 1'b0, 16'h0080},
        '{8'hFF, 8'h00, 1'b0, 16'h0000},
        '{8'h7F, 8'h7F, 1'b1, 16'h3F01},
        '{8'hFF, 8'hFF, 1'b1, 16'h0001}
    };

    seq_mult_sgn #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic signed [15:0] sx;
        logic signed [15:0] sy;
        logic [15:0] r;
        if (s) begin
            sx = {{8{x[7]}}, x};
            sy = {{8{y[7]}}, y};
            r  = 16'(sx * sy);
        end else begin
            r = {8'd0, x} * {8'd0, y};
        end
        return r;
    endfunction

    // Cycles counted inclusively from the accept edge to the edge raising out_valid.
    function automatic int exp_lat(input logic [7:0] y, input logic s);
`ifdef MULT_EARLY_EXIT_EN
        logic [7:0] m;
        int busy;
        m = (s && y[7]) ? (~y + 8'd1) : y;
        busy = 1;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) busy = i + 1;
        end
        return busy + 1;
`else
        return N + 1;
`endif
    endfunction

    task automatic drive_txn(input logic [7:0] x, input logic [7:0] y, input logic s,
                             input logic [15:0] expv,
                             output int lat, output logic [15:0] p, output bit ok);
        int g;
        @(negedge clk);
        a = x; b = y; is_signed = s; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        exp_q.push_back(expv);
        lat = 1;
        #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ok = out_valid;
        p  = product;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'd0; b = 8'd0; is_signed = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b product=%h, want 1 0 0000",
                     in_ready, out_valid, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        int lat;
        logic [15:0] p, e;
        bit ok;
        for (int i = 0; i < 13; i++) begin
            drive_txn(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, lat, p, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || p !== e) begin
                errors++;
                $display("FAIL vec%0d_product: a=%h b=%h s=%b got %h (valid=%b), want %h",
                         i, tbl[i].a, tbl[i].b, tbl[i].s, p, ok, e);
            end
            checks++;
            if (lat != exp_lat(tbl[i].b, tbl[i].s)) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d cycles, want %0d",
                         i, lat, exp_lat(tbl[i].b, tbl[i].s));
            end
            release_out();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_release: out_valid=%b in_ready=%b, want 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int seen;
        logic [15:0] p0, e;
        bit ok;
        drive_txn(8'hFD, 8'h05, 1'b1, 16'hFFF1, lat, p0, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || p0 !== e) begin
            errors++;
            $display("FAIL bp_product: got %h (valid=%b), want %h", p0, ok, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            a = 8'h11; b = 8'h22; is_signed = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || product !== e || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b product=%h in_ready=%b, want 1 %h 0",
                         i, out_valid, product, in_ready, e);
            end
        end
        in_valid = 1'b0;
        release_out();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ignored_input: out_valid seen %0d cycles, in_ready=%b, want 0 and 1",
                     seen, in_ready);
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat, seen;
        logic [15:0] p, e;
        bit ok;
        @(negedge clk);
        a = 8'h33; b = 8'h77; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b product=%h, want 1 0 0000",
                     in_ready, out_valid, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_no_pulse: out_valid seen %0d cycles, want 0", seen);
        end
        drive_txn(8'h07, 8'hFE, 1'b1, 16'hFFF2, lat, p, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || p !== e) begin
            errors++;
            $display("FAIL after_reset_product: got %h (valid=%b), want %h", p, ok, e);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] p, e;
        logic [7:0] x, y;
        logic s;
        bit ok;
        for (int i = 0; i < 24; i++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            drive_txn(x, y, s, model(x, y, s), lat, p, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || p !== e || lat != exp_lat(y, s)) begin
                errors++;
                $display("FAIL b2b%0d: a=%h b=%h s=%b got %h lat %0d, want %h lat %0d",
                         i, x, y, s, p, lat, e, exp_lat(y, s));
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
